// File: rtl/cnn_conv_mac_seq.sv
// Conv1D MAC sequencer: holds a KERNEL_LEN-tap sample window and coefficient bank, and
// time-multiplexes one external signed multiplier across the taps to produce each output.
module cnn_conv_mac_seq #(
  parameter int unsigned KERNEL_LEN = 12,
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned PROD_W     = 28,
  parameter int unsigned ACC_W      = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_idle,
  output logic              ap_done,
  input  logic [15:0]       n_out,
  input  logic [DATA_W-1:0] bias,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_din,
  input  logic [DATA_W-1:0] x_tdata,
  input  logic              x_tvalid,
  output logic              x_tready,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic [ACC_W-1:0]  y_tdata,
  output logic              y_tvalid,
  input  logic              y_tready
);

  localparam int unsigned KW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [KW-1:0] KLast    = KW'(KERNEL_LEN - 1);
  localparam logic [KW-1:0] FillLast = KW'(KERNEL_LEN - 2);
  localparam logic [4:0]    KLen5    = 5'(KERNEL_LEN);

  typedef enum logic [2:0] {StIdle, StFill, StWaitX, StMac, StAcc, StOut} state_e;

  state_e            r_state, w_state_next;
  logic [DATA_W-1:0] r_win  [KERNEL_LEN];
  logic [DATA_W-1:0] r_coef [KERNEL_LEN];
  logic [DATA_W-1:0] r_bias;
  logic [15:0]       r_n_out;
  logic [15:0]       r_out_cnt;
  logic [KW-1:0]     r_fill;
  logic [KW-1:0]     r_k;
  logic [PROD_W-1:0] r_p;
  logic [ACC_W-1:0]  r_acc;
  logic              r_done;

  logic             w_x_fire;
  logic             w_y_fire;
  logic             w_last_out;
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_bias_ext;

  assign w_x_fire   = x_tready & x_tvalid;
  assign w_y_fire   = y_tvalid & y_tready;
  assign w_last_out = (r_out_cnt + 16'd1) == r_n_out;
  assign w_p_ext    = {{(ACC_W-PROD_W){r_p[PROD_W-1]}}, r_p};
  assign w_bias_ext = {{(ACC_W-DATA_W){r_bias[DATA_W-1]}}, r_bias};
  assign ap_done    = r_done;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ap_idle      = 1'b0;
    x_tready     = 1'b0;
    y_tvalid     = 1'b0;
    y_tdata      = '0;
    mul_a        = '0;
    mul_b        = '0;
    unique case (r_state)
      StIdle: begin
        ap_idle = 1'b1;
        if (ap_start) w_state_next = StFill;
      end
      StFill: begin
        x_tready = 1'b1;
        if (x_tvalid && (r_fill == FillLast)) w_state_next = StWaitX;
      end
      StWaitX: begin
        x_tready = 1'b1;
        if (x_tvalid) w_state_next = StMac;
      end
      StMac: begin
        mul_a = r_win[r_k];
        mul_b = r_coef[r_k];
        if (r_k == KLast) w_state_next = StAcc;
      end
      StAcc: w_state_next = StOut;
      StOut: begin
        y_tvalid = 1'b1;
        y_tdata  = r_acc;
        if (y_tready) w_state_next = w_last_out ? StIdle : StWaitX;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // The multiplier product is registered, so each MAC cycle folds in the previous tap;
  // r_p is zeroed on the window-completing accept so tap 0 adds nothing stale.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      for (int i = 0; i < int'(KERNEL_LEN); i++) begin
        r_win[i]  <= '0;
        r_coef[i] <= '0;
      end
      r_bias    <= '0;
      r_n_out   <= '0;
      r_out_cnt <= '0;
      r_fill    <= '0;
      r_k       <= '0;
      r_p       <= '0;
      r_acc     <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == StIdle) begin
        if (coef_we && ({1'b0, coef_addr} < KLen5)) r_coef[coef_addr[KW-1:0]] <= coef_din;
        if (ap_start) begin
          r_n_out   <= (n_out == 16'd0) ? 16'd1 : n_out;
          r_bias    <= bias;
          r_fill    <= '0;
          r_out_cnt <= '0;
        end
      end
      if (w_x_fire) begin
        for (int i = int'(KERNEL_LEN) - 1; i > 0; i--) r_win[i] <= r_win[i-1];
        r_win[0] <= x_tdata;
      end
      if ((r_state == StFill) && w_x_fire) r_fill <= r_fill + KW'(1);
      if ((r_state == StWaitX) && w_x_fire) begin
        r_acc <= w_bias_ext;
        r_p   <= '0;
        r_k   <= '0;
      end
      if (r_state == StMac) begin
        r_acc <= r_acc + w_p_ext;
        r_p   <= mul_p;
        r_k   <= r_k + KW'(1);
      end
      if (r_state == StAcc) r_acc <= r_acc + w_p_ext;
      if ((r_state == StOut) && w_y_fire) begin
        r_out_cnt <= r_out_cnt + 16'd1;
        if (w_last_out) r_done <= 1'b1;
      end
    end
  end

endmodule
